mdio_master_arbiter: RTL and testbench

Two-requester MDIO master that shares a single MDIO serial link, clocked by MDC, between two host-side agents. It arbitrates round-robin and serializes one Clause-22 frame per grant: preamble, ST, OP, PHYAD, REGAD, TA and 16 data bits. It drives MDIO_OUT and MDIO_OE toward the MDIO receiver/PHY side and captures MDIO_IN on reads. It sits between the management agents and the MDIO transaction receiver.

---
 rtl/mdio_master_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mdio_master_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master_arbiter.sv
// Two-requester round-robin Clause-22 MDIO master.
// One frame per grant; all pin outputs registered one cycle behind the FSM.
module mdio_master_arbiter #(
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        MDC,
  input  logic        reset,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        RW0,
  input  logic        RW1,
  input  logic [4:0]  PHYAD0,
  input  logic [4:0]  PHYAD1,
  input  logic [4:0]  REGAD0,
  input  logic [4:0]  REGAD1,
  input  logic [15:0] WDATA0,
  input  logic [15:0] WDATA1,
  input  logic        MDIO_IN,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [1:0]  GNT,
  output logic        DONE0,
  output logic        DONE1,
  output logic [15:0] RDATA
);

  typedef enum logic [2:0] {
    IDLE, PRE, HDR, TA, DATA, FIN
  } state_t;

  localparam logic [5:0] PRE_LAST =
    6'(PREAMBLE_LEN - 1);

  state_t      state, state_nx;
  logic [5:0]  cnt, cnt_nx;
  logic        own, last, win, grant;
  logic        rw;
  logic [4:0]  phy, rad;
  logic [15:0] wd, shreg;
  logic [13:0] hdr;
  logic        oe_c, out_c, fin;
  logic [1:0]  gnt_c;

  // Tie goes to whoever was not granted last.
  assign win   = (REQ0 && REQ1) ? ~last : REQ1;
  assign hdr   = {2'b01, rw, ~rw, phy, rad};
  assign fin   = (state == FIN);
  assign gnt_c = (state == IDLE) ? 2'b00 :
                 (own ? 2'b10 : 2'b01);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 6'd1;
    grant    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = 6'd0;
        if (REQ0 || REQ1) begin
          grant    = 1'b1;
          state_nx = (PREAMBLE_LEN == 0) ? HDR : PRE;
        end
      end
      PRE: if (cnt == PRE_LAST) begin
        state_nx = HDR;
        cnt_nx   = 6'd0;
      end
      HDR: if (cnt == 6'd13) begin
        state_nx = TA;
        cnt_nx   = 6'd0;
      end
      TA: if (cnt == 6'd1) begin
        state_nx = DATA;
        cnt_nx   = 6'd0;
      end
      DATA: if (cnt == 6'd15) begin
        state_nx = FIN;
        cnt_nx   = 6'd0;
      end
      FIN: begin
        state_nx = IDLE;
        cnt_nx   = 6'd0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 6'd0;
      end
    endcase
  end

  always_comb begin
    oe_c  = 1'b0;
    out_c = 1'b1;
    unique case (state)
      PRE: oe_c = 1'b1;
      HDR: begin
        oe_c  = 1'b1;
        out_c = hdr[4'd13 - cnt[3:0]];
      end
      TA: if (!rw) begin
        oe_c  = 1'b1;
        out_c = (cnt == 6'd0);
      end
      DATA: if (!rw) begin
        oe_c  = 1'b1;
        out_c = wd[4'd15 - cnt[3:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge MDC or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge MDC or posedge reset) begin
    if (reset) begin
      own   <= 1'b0;
      last  <= 1'b1;
      rw    <= 1'b0;
      phy   <= 5'd0;
      rad   <= 5'd0;
      wd    <= 16'd0;
      shreg <= 16'd0;
    end else begin
      if (grant) begin
        own <= win;
        rw  <= win ? RW1 : RW0;
        phy <= win ? PHYAD1 : PHYAD0;
        rad <= win ? REGAD1 : REGAD0;
        wd  <= win ? WDATA1 : WDATA0;
      end
      // Each edge that closes a visible data bit samples it.
      if (state == DATA && cnt != 6'd0 && rw)
        shreg <= {shreg[14:0], MDIO_IN};
      if (fin)
        last <= own;
    end
  end

  always_ff @(posedge MDC or posedge reset) begin
    if (reset) begin
      MDIO_OUT <= 1'b1;
      MDIO_OE  <= 1'b0;
      GNT      <= 2'b00;
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
      RDATA    <= 16'd0;
    end else begin
      MDIO_OUT <= out_c;
      MDIO_OE  <= oe_c;
      GNT      <= gnt_c;
      DONE0    <= fin && !own;
      DONE1    <= fin && own;
      if (fin && rw)
        RDATA <= {shreg[14:0], MDIO_IN};
    end
  end

endmodule

// File: tb/tb_mdio_master_arbiter.sv
// Directed scoreboard bench for mdio_master_arbiter.
// Second instance covers the zero-preamble configuration.
module tb_mdio_master_arbiter;

  logic        MDC, reset;
  logic        REQ0, REQ1, RW0, RW1;
  logic [4:0]  PHYAD0, PHYAD1, REGAD0, REGAD1;
  logic [15:0] WDATA0, WDATA1;
  logic        MDIO_IN;

  logic        out_a, oe_a, d0_a, d1_a;
  logic [1:0]  gnt_a;
  logic [15:0] rd_a;
  logic        out_z, oe_z, d0_z, d1_z;
  logic [1:0]  gnt_z;
  logic [15:0] rd_z;

  logic        zsel;
  logic        m_out, m_oe, m_d0, m_d1;
  logic [1:0]  m_gnt;
  logic [15:0] m_rd;

  int          total, bad;
  logic [15:0] last_rd;

  typedef struct packed {
    logic oe;
    logic out;
    logic drv;
    logic din;
  } bit_t;

  bit_t q[$];

  mdio_master_arbiter #(.PREAMBLE_LEN(32)) u_a (
    .MDC(MDC), .reset(reset),
    .REQ0(REQ0), .REQ1(REQ1), .RW0(RW0), .RW1(RW1),
    .PHYAD0(PHYAD0), .PHYAD1(PHYAD1),
    .REGAD0(REGAD0), .REGAD1(REGAD1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .MDIO_IN(MDIO_IN), .MDIO_OUT(out_a), .MDIO_OE(oe_a),
    .GNT(gnt_a), .DONE0(d0_a), .DONE1(d1_a), .RDATA(rd_a)
  );

  mdio_master_arbiter #(.PREAMBLE_LEN(0)) u_z (
    .MDC(MDC), .reset(reset),
    .REQ0(REQ0), .REQ1(REQ1), .RW0(RW0), .RW1(RW1),
    .PHYAD0(PHYAD0), .PHYAD1(PHYAD1),
    .REGAD0(REGAD0), .REGAD1(REGAD1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .MDIO_IN(MDIO_IN), .MDIO_OUT(out_z), .MDIO_OE(oe_z),
    .GNT(gnt_z), .DONE0(d0_z), .DONE1(d1_z), .RDATA(rd_z)
  );

  initial MDC = 1'b0;
  always #5 MDC = ~MDC;

  always_comb begin
    m_out = zsel ? out_z : out_a;
    m_oe  = zsel ? oe_z  : oe_a;
    m_d0  = zsel ? d0_z  : d0_a;
    m_d1  = zsel ? d1_z  : d1_a;
    m_gnt = zsel ? gnt_z : gnt_a;
    m_rd  = zsel ? rd_z  : rd_a;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(
    input bit          z,
    input int          pl,
    input bit          who,
    input bit          rw,
    input logic [4:0]  phy,
    input logic [4:0]  ra,
    input logic [15:0] wd,
    input logic [15:0] rd,
    input bit          drop,
    input int          exp_wait,
    input int          chg_at,
    input logic [15:0] nw
  );
    logic [13:0] hdr;
    logic [1:0]  eg;
    bit_t        e;
    int          n;
    int          i;
    zsel = z;
    q.delete();
    hdr = {2'b01, rw, ~rw, phy, ra};
    for (int k = 0; k < pl; k++) q.push_back(4'b1100);
    for (int k = 13; k >= 0; k--)
      q.push_back({1'b1, hdr[k], 2'b00});
    if (rw) begin
      q.push_back(4'b0100);
      q.push_back(4'b0100);
    end else begin
      q.push_back(4'b1100);
      q.push_back(4'b1000);
    end
    for (int k = 15; k >= 0; k--)
      if (rw) q.push_back({2'b01, 1'b1, rd[k]});
      else    q.push_back({1'b1, wd[k], 2'b00});
    eg = who ? 2'b10 : 2'b01;
    n = 0;
    do begin
      @(negedge MDC);
      n++;
    end while (m_gnt == 2'b00 && n < 200);
    chk("gnt_wait", n, exp_wait);
    if (drop) begin
      REQ0 = 1'b0;
      REQ1 = 1'b0;
    end
    i = 0;
    while (q.size() != 0) begin
      e = q.pop_front();
      chk("oe", m_oe, e.oe);
      chk("out", m_out, e.out);
      chk("gnt", m_gnt, eg);
      chk("done_lo", {m_d1, m_d0}, 2'b00);
      if (e.drv) MDIO_IN = e.din;
      if (i == chg_at) begin
        WDATA0 = nw;
        REQ0   = 1'b0;
      end
      @(negedge MDC);
      i++;
    end
    if (rw) last_rd = rd;
    chk("done", {m_d1, m_d0}, eg);
    chk("fin_gnt", m_gnt, eg);
    chk("fin_oe", m_oe, 1'b0);
    chk("fin_out", m_out, 1'b1);
    chk("rdata", m_rd, last_rd);
    @(negedge MDC);
    chk("idle_gnt", m_gnt, 2'b00);
    chk("idle_done", {m_d1, m_d0}, 2'b00);
    chk("idle_oe", m_oe, 1'b0);
  endtask

  initial begin
    int n;
    total = 0; bad = 0; zsel = 1'b0; last_rd = 16'h0;
    reset = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    RW0 = 1'b0; RW1 = 1'b0;
    PHYAD0 = 5'h0; PHYAD1 = 5'h0;
    REGAD0 = 5'h0; REGAD1 = 5'h0;
    WDATA0 = 16'h0; WDATA1 = 16'h0;
    MDIO_IN = 1'b0;

    // reset state
    @(negedge MDC);
    chk("rst_out", out_a, 1'b1);
    chk("rst_oe", oe_a, 1'b0);
    chk("rst_gnt", gnt_a, 2'b00);
    chk("rst_done", {d1_a, d0_a}, 2'b00);
    chk("rst_rdata", rd_a, 16'h0);
    reset = 1'b0;
    @(negedge MDC);
    chk("idle_out", out_a, 1'b1);
    chk("idle_gnt0", gnt_a, 2'b00);

    // write from requester 0
    RW0 = 1'b0; PHYAD0 = 5'h03; REGAD0 = 5'h11;
    WDATA0 = 16'hA5C3; REQ0 = 1'b1;
    run_frame(0, 32, 0, 0, 5'h03, 5'h11, 16'hA5C3,
              16'h0, 1, 2, -1, 16'h0);

    // read from requester 1
    RW1 = 1'b1; PHYAD1 = 5'h1F; REGAD1 = 5'h02;
    REQ1 = 1'b1;
    run_frame(0, 32, 1, 1, 5'h1F, 5'h02, 16'h0,
              16'h3C96, 1, 2, -1, 16'h0);

    // inputs change and REQ drops mid-DATA
    RW0 = 1'b0; PHYAD0 = 5'h0A; REGAD0 = 5'h15;
    WDATA0 = 16'h1234; REQ0 = 1'b1;
    run_frame(0, 32, 0, 0, 5'h0A, 5'h15, 16'h1234,
              16'h0, 0, 2, 32 + 16 + 8, 16'hFFFF);
    repeat (4) begin
      @(negedge MDC);
      chk("no_refr", gnt_a, 2'b00);
    end

    // reset during HDR
    WDATA0 = 16'hBEEF; PHYAD0 = 5'h05; REGAD0 = 5'h06;
    REQ0 = 1'b1;
    n = 0;
    do begin
      @(negedge MDC);
      n++;
    end while (gnt_a == 2'b00 && n < 200);
    chk("mid_gnt", n, 2);
    repeat (32 + 5) @(negedge MDC);
    reset = 1'b1;
    #1;
    chk("mid_oe", oe_a, 1'b0);
    chk("mid_out", out_a, 1'b1);
    chk("mid_gnt0", gnt_a, 2'b00);
    chk("mid_done", {d1_a, d0_a}, 2'b00);
    chk("mid_rdata", rd_a, 16'h0);
    @(negedge MDC);
    chk("mid_done2", {d1_a, d0_a}, 2'b00);
    reset = 1'b0;
    last_rd = 16'h0;
    run_frame(0, 32, 0, 0, 5'h05, 5'h06, 16'hBEEF,
              16'h0, 1, 2, -1, 16'h0);

    // tie from reset, both held
    reset = 1'b1;
    RW0 = 1'b0; PHYAD0 = 5'h01; REGAD0 = 5'h04;
    WDATA0 = 16'h5A5A;
    RW1 = 1'b1; PHYAD1 = 5'h12; REGAD1 = 5'h1E;
    REQ0 = 1'b1; REQ1 = 1'b1;
    @(negedge MDC);
    reset = 1'b0;
    last_rd = 16'h0;
    run_frame(0, 32, 0, 0, 5'h01, 5'h04, 16'h5A5A,
              16'h0, 0, 2, -1, 16'h0);
    run_frame(0, 32, 1, 1, 5'h12, 5'h1E, 16'h0,
              16'hC3A5, 0, 1, -1, 16'h0);
    run_frame(0, 32, 0, 0, 5'h01, 5'h04, 16'h5A5A,
              16'h0, 0, 1, -1, 16'h0);
    run_frame(0, 32, 1, 1, 5'h12, 5'h1E, 16'h0,
              16'h0F0F, 1, 1, -1, 16'h0);

    // zero-length preamble write
    reset = 1'b1;
    RW0 = 1'b0; PHYAD0 = 5'h07; REGAD0 = 5'h19;
    WDATA0 = 16'hC001; REQ0 = 1'b1;
    @(negedge MDC);
    reset = 1'b0;
    last_rd = 16'h0;
    run_frame(1, 0, 0, 0, 5'h07, 5'h19, 16'hC001,
              16'h0, 1, 2, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
